// File: rtl/dma_mm2s_burst_engine.sv
// MM2S DMA burst engine: splits a (address, beat-count) command into AXI4 INCR
// read bursts that never cross a 4 KB page, and forwards the data to AXI-Stream.
module dma_mm2s_burst_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  // Intermediate width wide enough for the remaining count and the page room (up to 4096).
  localparam int CW    = (LEN_WIDTH + 1 > 14) ? LEN_WIDTH + 1 : 14;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [8:0]            burst_beats;
  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] burst_bytes;

  function automatic logic [8:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                            input logic [LEN_WIDTH-1:0]  r);
    logic [CW-1:0] rem_w;
    logic [CW-1:0] room_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] b;
    rem_w  = CW'(r);
    room_w = CW'((13'd4096 - {1'b0, a[11:0]}) >> SIZE);
    max_w  = CW'(MAX_BURST);
    b = rem_w;
    if (room_w < b) b = room_w;
    if (max_w < b)  b = max_w;
    return b[8:0];
  endfunction

  assign r_hs        = (state_q == S_DATA) && m_axi_rvalid && m_axis_tready;
  assign burst_bytes = ADDR_WIDTH'({1'b0, arlen_q} + 9'd1) << SIZE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    burst_beats = '0;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          addr_d = i_cmd_addr & ALIGN_MASK;
          rem_d  = i_cmd_len;
          err_d  = 1'b0;
          if (i_cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ADDR;
            burst_beats = calc_beats(addr_d, rem_d);
            araddr_d    = addr_d;
            arlen_d     = 8'(burst_beats - 9'd1);
          end
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          state_d    = S_DATA;
          beat_cnt_d = {1'b0, arlen_q} + 9'd1;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          rem_d      = rem_q - 1'b1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          if (m_axi_rlast != (beat_cnt_q == 9'd1)) err_d = 1'b1;
          if (beat_cnt_q == 9'd1) begin
            addr_d = addr_q + burst_bytes;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = S_DONE;
            end else begin
              // Next burst is sized from the post-increment address and count.
              state_d     = S_ADDR;
              burst_beats = calc_beats(addr_d, rem_d);
              araddr_d    = addr_d;
              arlen_d     = 8'(burst_beats - 9'd1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
    end
  end

  assign o_cmd_ready   = (state_q == S_IDLE) && !rst;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_err         = (state_q == S_DONE) && err_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == S_ADDR);
  // R channel is a straight passthrough so downstream backpressure stalls the slave.
  assign m_axi_rready  = (state_q == S_DATA) && m_axis_tready;
  assign m_axis_tvalid = (state_q == S_DATA) && m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = (state_q == S_DATA) && m_axi_rvalid &&
                         (beat_cnt_q == 9'd1) && (rem_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_dma_mm2s_burst_engine.sv
// Directed bench for dma_mm2s_burst_engine: AXI read slave model plus stream sink.
module tb_dma_mm2s_burst_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [AW-1:0] i_cmd_addr;
  logic [LW-1:0] i_cmd_len;
  logic          o_busy, o_done, o_err;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  dma_mm2s_burst_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] exp_ar[$];  // {araddr, arlen} expected in order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar.push_back({a, l});
  endtask

  // Runs one command against the slave model. slverr_idx/rlast_idx select the
  // beat (0-based) that gets SLVERR / a forced RLAST; abort_at >= 0 resets mid-DATA.
  task automatic run_cmd(input logic [31:0] addr, input int len, input bit bp,
                         input int slverr_idx, input int rlast_idx, input bit exp_err,
                         input int abort_at);
    int          ars = 0, beats = 0, tlasts = 0, done_cnt = 0;
    int          burst_left = 0, ar_wait = 0, cyc = 0, last_hs = -10;
    bit          aborted = 0;
    logic [39:0] e;
    logic [31:0] hold = '0;
    logic [31:0] beat_addr = '0;
    logic [31:0] base;
    logic [15:0] lfsr = 16'hACE1;
    base = addr & 32'hFFFF_FFFC;

    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = addr;
    i_cmd_len   = LW'(len);
    #1;
    check("cmd_ready_idle", 64'(o_cmd_ready), 64'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;

    while (cyc < 2000 && done_cnt == 0) begin
      if (abort_at >= 0 && beats == abort_at) begin
        aborted = 1;
        break;
      end
      if (m_axi_arvalid) begin
        if (ar_wait == 0) hold = m_axi_araddr;
        else check("araddr_stable", 64'(m_axi_araddr), 64'(hold));
        ar_wait++;
      end
      m_axi_arready = m_axi_arvalid && (ar_wait >= 2) && (burst_left == 0);
      m_axi_rvalid  = (burst_left > 0);
      m_axi_rdata   = beat_addr;
      m_axi_rresp   = (burst_left > 0 && beats == slverr_idx) ? 2'b10 : 2'b00;
      m_axi_rlast   = (burst_left == 1) || (burst_left > 0 && beats == rlast_idx);
      m_axis_tready = bp ? lfsr[0] : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      #1;
      if (cyc == 0 && len > 0) begin
        check("busy", 64'(o_busy), 64'd1);
        check("cmd_ready_busy", 64'(o_cmd_ready), 64'd0);
      end
      if (o_done) begin
        done_cnt++;
        check("err", 64'(o_err), 64'(exp_err));
        if (len == 0) check("done_latency_len0", 64'(cyc), 64'd0);
        else check("done_after_last_hs", 64'(cyc - last_hs), 64'd1);
      end
      if (burst_left > 0) check("rready_eq_tready", 64'(m_axi_rready), 64'(m_axis_tready));
      if (m_axi_rvalid && m_axi_rready) begin
        check("tvalid", 64'(m_axis_tvalid), 64'd1);
        check("tdata", 64'(m_axis_tdata), 64'(base + 32'(beats) * 32'd4));
        check("tlast", 64'(m_axis_tlast), 64'(beats == len - 1));
        if (m_axis_tlast) tlasts++;
        beats++;
        burst_left--;
        beat_addr += 32'd4;
        last_hs = cyc;
      end else if (m_axis_tvalid && m_axis_tready) begin
        check("stream_without_r", 64'd1, 64'd0);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ars++;
        if (exp_ar.size() == 0) begin
          check("ar_extra", 64'(m_axi_araddr), 64'hDEAD);
        end else begin
          e = exp_ar.pop_front();
          check("araddr", 64'(m_axi_araddr), 64'(e[39:8]));
          check("arlen", 64'(m_axi_arlen), 64'(e[7:0]));
          check("no_4k_cross",
                64'((32'(m_axi_araddr[11:0]) + (32'(m_axi_arlen) + 32'd1) * 32'd4) <= 32'd4096),
                64'd1);
        end
        burst_left = int'(m_axi_arlen) + 1;
        beat_addr  = m_axi_araddr;
        ar_wait    = 0;
      end
      @(negedge clk);
      cyc++;
    end

    if (aborted) begin
      rst = 1'b1;
      @(negedge clk);
      check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_cmd_ready", 64'(o_cmd_ready), 64'd0);
      rst = 1'b0;
      m_axi_rvalid = 1'b0;
      m_axi_arready = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    end else begin
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_arready = 1'b0;
      #1;
      check("done_seen", 64'(done_cnt), 64'd1);
      check("beat_count", 64'(beats), 64'(len));
      check("tlast_count", 64'(tlasts), 64'(len > 0));
      check("done_one_cycle", 64'(o_done), 64'd0);
      check("idle_ready", 64'(o_cmd_ready), 64'd1);
      check("idle_busy", 64'(o_busy), 64'd0);
    end
    check("ar_remaining", 64'(exp_ar.size()), 64'd0);
    exp_ar.delete();
    $display("[TB] cmd addr=0x%08h len=%0d ars=%0d beats=%0d err=%0b aborted=%0b",
             addr, len, ars, beats, exp_err, aborted);
  endtask

  initial begin
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_addr = '0;
    i_cmd_len = '0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(o_cmd_ready), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_err", 64'(o_err), 64'd0);
    check("reset_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("reset_rready", 64'(m_axi_rready), 64'd0);
    check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset_tlast", 64'(m_axis_tlast), 64'd0);
    check("reset_araddr", 64'(m_axi_araddr), 64'd0);
    check("reset_arlen", 64'(m_axi_arlen), 64'd0);
    check("arsize", 64'(m_axi_arsize), 64'd2);
    check("arburst", 64'(m_axi_arburst), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_cmd_ready", 64'(o_cmd_ready), 64'd1);

    // Single burst
    push_ar(32'h1000, 8'd3);
    run_cmd(32'h1000, 4, 0, -1, -1, 0, -1);
    // Multi-burst split
    push_ar(32'h000, 8'd15); push_ar(32'h040, 8'd15); push_ar(32'h080, 8'd7);
    run_cmd(32'h0, 40, 0, -1, -1, 0, -1);
    // 4 KB crossing
    push_ar(32'h0FF8, 8'd1); push_ar(32'h1000, 8'd2);
    run_cmd(32'h0FF8, 5, 0, -1, -1, 0, -1);
    // Backpressure
    push_ar(32'h2000, 8'd15); push_ar(32'h2040, 8'd3);
    run_cmd(32'h2000, 20, 1, -1, -1, 0, -1);
    // SLVERR on beat 2, then early RLAST on beat 3
    push_ar(32'h3000, 8'd3);
    run_cmd(32'h3000, 4, 0, 1, -1, 1, -1);
    push_ar(32'h3000, 8'd3);
    run_cmd(32'h3000, 4, 0, -1, 2, 1, -1);
    // Sticky error cleared by the next command
    push_ar(32'h3100, 8'd3);
    run_cmd(32'h3100, 4, 0, -1, -1, 0, -1);
    // Unaligned start address is forced down to the beat boundary
    push_ar(32'h6000, 8'd3);
    run_cmd(32'h6002, 4, 0, -1, -1, 0, -1);
    // Zero length
    run_cmd(32'h5000, 0, 0, -1, -1, 0, -1);
    // Reset mid-DATA, then recovery
    push_ar(32'h4000, 8'd15);
    run_cmd(32'h4000, 20, 0, -1, -1, 0, 5);
    push_ar(32'h7000, 8'd1);
    run_cmd(32'h7000, 2, 0, -1, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_mm2s_burst_engine.md
Name: dma_mm2s_burst_engine

Overview:
- Parametrised MM2S DMA engine. Accepts a command (start address, length in beats) and issues AXI4 INCR read bursts of up to MAX_BURST beats.
- Bursts are split so that none crosses a 4 KB boundary. Read data is forwarded to an AXI4-Stream master with TLAST on the final beat of the command.
- Sits between the control/descriptor logic and the AXI interconnect. It is the burst-capable successor of the single-beat DMA path.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI/stream data width; power of two, 32..256
LEN_WIDTH, 16, width of the command length field (beats)
MAX_BURST, 16, maximum beats per AXI burst; power of two, 1..256

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  high only in IDLE
i_cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits forced to 0
i_cmd_len  in  LEN_WIDTH  transfer length in beats
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  valid with o_done; 1 if any RRESP!=OKAY or RLAST mismatch
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(DATA_WIDTH/8), constant
m_axi_arburst  out  2  2'b01 INCR, constant
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tlast  out  1  last beat of command
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: o_cmd_ready=0 during reset and 1 the cycle after. o_busy, o_done, o_err, m_axi_arvalid, m_axi_rready, m_axis_tvalid, m_axis_tlast=0. m_axi_araddr=0, m_axi_arlen=0.
- States:
  - IDLE: a command is accepted on i_cmd_valid && o_cmd_ready. Latch addr (aligned) and remaining=i_cmd_len, clear the sticky err. Go to ADDR, or go to DONE if i_cmd_len==0.
  - ADDR: m_axi_arvalid=1. araddr/arlen are registered and stable until m_axi_arready. Then go to DATA, load beat_cnt=arlen+1.
  - DATA: passthrough. m_axi_rready=m_axis_tready, m_axis_tvalid=m_axi_rvalid, m_axis_tdata=m_axi_rdata.
    - Each handshake (rvalid&&rready) decrements beat_cnt and remaining.
    - On the burst's final beat: addr += beats*(DATA_WIDTH/8). Go to DONE if remaining reaches 0, else back to ADDR.
  - DONE: o_done=1 for exactly one cycle, o_err=sticky err. Then go to IDLE.
- Burst size: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)). arlen = beats-1. Computed with LEN_WIDTH+1 bit intermediates, no truncation.
- TLAST: m_axis_tlast = m_axi_rvalid && beat_cnt==1 && remaining==1.
- Only one burst is outstanding. The next AR is issued no earlier than the cycle after the previous burst's final R handshake.
- Errors (all set the sticky err; none abort the transfer, all beats are still forwarded):
  - rresp!=2'b00 on any beat.
  - rlast=1 with beat_cnt!=1.
  - rlast=0 with beat_cnt==1.
- Backpressure: the engine never drops or reorders data. While m_axis_tready=0, m_axi_rready=0.
- Commands presented while busy are ignored; o_cmd_ready=0.
- Address increment wraps modulo 2^ADDR_WIDTH. There is no special handling beyond 4 KB splitting.
- Reset mid-operation: at the next clk edge with rst=1 the state returns to IDLE and all valids deassert. In-flight AXI beats are abandoned. The surrounding system resets the interconnect together with the engine.

Test Plan (DATA_WIDTH=32, MAX_BURST=16):
1. Single burst: addr 0x1000, len 4. Expect one AR: araddr=0x1000, arlen=3. Four stream beats, tlast on beat 4 only. o_done pulses 1 cycle, o_err=0.
2. Multi-burst split: addr 0x0, len 40. Expect ARs (0x000, arlen 15), (0x040, arlen 15), (0x080, arlen 7). 40 beats in order, tlast once.
3. 4 KB crossing: addr 0x0FF8, len 5. Expect (0x0FF8, arlen 1), then (0x1000, arlen 2). No burst crosses 0x1000.
4. Backpressure: len 20 with tready toggled pseudo-randomly (~50%). Expect rready==tready in DATA, data sequence intact, done after the 20th handshake.
5. Errors: rresp=SLVERR on beat 2 of len 4. Expect all 4 beats forwarded, done with o_err=1. A separate run with early rlast on beat 3 of 4 also gives o_err=1.
6. Edge cases:
   - len 0: no arvalid, o_done the cycle after acceptance, o_err=0.
   - rst asserted mid-DATA: arvalid/tvalid/o_busy=0 the following cycle, o_cmd_ready=1 the cycle after rst deasserts.
